sisc_ctrl_fsm: RTL and testbench
================================

Name: sisc_ctrl_fsm

Overview:
- Multicycle control unit of the SISC processor.
- Sequences each instruction through the fixed phase order fetch → decode → execute → mem → writeback.
- Decodes opcode/mm from the instruction register and evaluates branch conditions against the status register.
- Drives every datapath enable and select (pc, ir, br, alu, rf, dm, address mux, swap path).

Parameters:
- none (all encodings are constants in the shared package)

Ports:
- clk       in   1  system clock, rising edge
- rst_f     in   1  asynchronous reset, active-low
- opcode    in   4  instruction[31:28]
- mm        in   4  instruction[27:24]; branch condition mask / address mode
- stat      in   4  status register {C,N,V,Z}
- rf_we     out  1  register file write enable
- alu_op    out  2  00 reg-reg, 01 reg-imm, 10 address (rs+imm), 11 unused
- wb_sel    out  2  write data: 00 alu_result, 01 dm read_data, 10 rsa, 11 rsb
- rb_sel    out  1  regfile port B address: 0 rt [15:12], 1 rd [23:20]
- pc_sel    out  1  pc source: 0 pc+1, 1 branch target
- pc_write  out  1  pc load enable
- pc_rst    out  1  pc clear
- ir_load   out  1  instruction register load
- br_sel    out  1  branch target: 1 absolute imm, 0 pc+imm
- mm_sel    out  1  dm address: 0 imm[15:0], 1 alu_result[15:0]
- dm_we     out  1  data memory write enable
- swap_sel  out  1  write register: 0 rd [23:20], 1 rs [19:16]
- swap_ctrl out  1  datapath captures rsa/rsb for swap

Behaviour:
- Reset (rst_f=0, asynchronous):
  - state ← START0.
  - pc_rst=1 while in reset and in START0.
  - All other outputs 0.
- State sequence: START0 → START1 → FETCH → DECODE → EXECUTE → MEM → WB → FETCH.
  - SWP only: WB → SWAP2 → FETCH.
  - HLT: DECODE → HALT; HALT is held until reset, all outputs 0.
- Outputs: combinational from state and opcode. Every output defaults to 0 in every state unless listed below.
- Opcodes:
  - 0000 NOP
  - 0001 ALU reg
  - 0010 BRA
  - 0011 BRR
  - 0100 BNE
  - 0101 BNR
  - 0110 ALU imm
  - 1000 LOD
  - 1001 STR
  - 1010 SWP
  - 1111 HLT
  - Any undefined opcode behaves as NOP (full cycle, no side effects).
- FETCH: ir_load=1, pc_write=1, pc_sel=0.
- DECODE, branches:
  - br_sel=1 for BRA/BNE, 0 for BRR/BNR.
  - BRA/BRR taken when mm==0000 or (mm & stat)!=0.
  - BNE/BNR taken when (mm & stat)==0.
  - Taken: pc_sel=1, pc_write=1. Relative target is based on the already-incremented pc.
- EXECUTE: alu_op = 00 (ALU reg), 01 (ALU imm), 10 (LOD/STR), 00 otherwise.
- rb_sel=1 for STR and SWP in DECODE through SWAP2; 0 otherwise.
- mm_sel = ~mm[3] for LOD/STR in EXECUTE, MEM and WB.
  - mm[3]=1 selects the absolute immediate address.
  - mm[3]=0 selects the rs+imm address.
- MEM: STR → dm_we=1 (single cycle). SWP → swap_ctrl=1.
- WB:
  - ALU reg/imm: rf_we=1, wb_sel=00, swap_sel=0.
  - LOD: rf_we=1, wb_sel=01.
  - SWP: rf_we=1, wb_sel=10, swap_sel=0 (rd ← old rs).
- SWAP2: rf_we=1, wb_sel=11, swap_sel=1 (rs ← old rd).
- rf_we and dm_we are never asserted outside WB/SWAP2 and MEM respectively.
- At most one pc_write per non-branch instruction.
- Reset mid-instruction: immediate return to START0; no write enable may be asserted on the following edge.

Decomposition:
- Package sisc_pkg holds:
  - opcode constants
  - state enum (START0, START1, FETCH, DECODE, EXECUTE, MEM, WB, SWAP2, HALT)
  - alu_op and wb_sel codes
  - a branch_taken(opcode, mm, stat) function
- No sub-module; single FSM with a registered state and a combinational output block.

Test Plan:
- Reset, then release rst_f → pc_rst=1 in START0. FETCH on the 3rd edge shows ir_load=1, pc_write=1, pc_sel=0.
- opcode=0001 → EXECUTE alu_op=00; WB rf_we=1, wb_sel=00; back to FETCH after 5 cycles. Same sequence with 0110 gives alu_op=01.
- BRA with mm=0001: stat=0001 → DECODE pc_sel=1, pc_write=1, br_sel=1. stat=0000 → no pc_write.
- BNR with mm=0100: stat=0000 → taken, br_sel=0. stat=0100 → not taken. Also BRR with mm=0000 is always taken.
- STR with mm=1000 → rb_sel=1, MEM dm_we=1, mm_sel=0, no rf_we.
- LOD with mm=0000 → alu_op=10, WB rf_we=1, wb_sel=01, mm_sel=1.
- SWP → MEM swap_ctrl=1; WB wb_sel=10, swap_sel=0; SWAP2 wb_sel=11, swap_sel=1.
- HLT → all outputs 0 for 10 cycles.
- rst_f low during WB → rf_we drops immediately.

Source files
------------

// File: rtl/sisc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sisc_pkg
// Description : Shared encodings for the SISC multicycle control unit:
//               opcodes, FSM state codes, alu_op / wb_sel codes and the
//               branch condition evaluation function.
// Revision    : 1.0 - initial release
// ============================================================================
package sisc_pkg;

    // Opcodes, instruction[31:28]
    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_ALUR = 4'b0001;
    localparam logic [3:0] OP_BRA  = 4'b0010;
    localparam logic [3:0] OP_BRR  = 4'b0011;
    localparam logic [3:0] OP_BNE  = 4'b0100;
    localparam logic [3:0] OP_BNR  = 4'b0101;
    localparam logic [3:0] OP_ALUI = 4'b0110;
    localparam logic [3:0] OP_LOD  = 4'b1000;
    localparam logic [3:0] OP_STR  = 4'b1001;
    localparam logic [3:0] OP_SWP  = 4'b1010;
    localparam logic [3:0] OP_HLT  = 4'b1111;

    // Control FSM states
    localparam logic [3:0] S_START0  = 4'd0;
    localparam logic [3:0] S_START1  = 4'd1;
    localparam logic [3:0] S_FETCH   = 4'd2;
    localparam logic [3:0] S_DECODE  = 4'd3;
    localparam logic [3:0] S_EXECUTE = 4'd4;
    localparam logic [3:0] S_MEM     = 4'd5;
    localparam logic [3:0] S_WB      = 4'd6;
    localparam logic [3:0] S_SWAP2   = 4'd7;
    localparam logic [3:0] S_HALT    = 4'd8;

    // ALU operand selection
    localparam logic [1:0] ALU_REG = 2'b00;
    localparam logic [1:0] ALU_IMM = 2'b01;
    localparam logic [1:0] ALU_ADR = 2'b10;

    // Register file write data source
    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_DM  = 2'b01;
    localparam logic [1:0] WB_RSA = 2'b10;
    localparam logic [1:0] WB_RSB = 2'b11;

    // mm is the condition mask, stat is {C,N,V,Z}. An all-zero mask on the
    // "branch if set" forms means unconditional.
    function automatic logic branch_taken(input logic [3:0] op,
                                          input logic [3:0] mm,
                                          input logic [3:0] stat);
        logic taken;
        taken = 1'b0;
        case (op)
            OP_BRA, OP_BRR: taken = (mm == 4'b0000) || ((mm & stat) != 4'b0000);
            OP_BNE, OP_BNR: taken = ((mm & stat) == 4'b0000);
            default:        taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sisc_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : sisc_ctrl_fsm
// Description : Multicycle control unit of the SISC processor. Steps each
//               instruction through fetch, decode, execute, mem and
//               writeback, and drives all datapath enables and selects.
// Ports       : clk, rst_f (async, active-low)
//               opcode/mm from the IR, stat = {C,N,V,Z}
//               rf_we, alu_op, wb_sel, rb_sel, pc_sel, pc_write, pc_rst,
//               ir_load, br_sel, mm_sel, dm_we, swap_sel, swap_ctrl
// Revision    : 1.0 - initial release
// ============================================================================
module sisc_ctrl_fsm
    import sisc_pkg::*;
(
    input  logic       clk,
    input  logic       rst_f,
    input  logic [3:0] opcode,
    input  logic [3:0] mm,
    input  logic [3:0] stat,
    output logic       rf_we,
    output logic [1:0] alu_op,
    output logic [1:0] wb_sel,
    output logic       rb_sel,
    output logic       pc_sel,
    output logic       pc_write,
    output logic       pc_rst,
    output logic       ir_load,
    output logic       br_sel,
    output logic       mm_sel,
    output logic       dm_we,
    output logic       swap_sel,
    output logic       swap_ctrl
);

    logic [3:0] state_q;
    logic [3:0] state_d;

    logic is_mem_op;    // LOD/STR use the address mux
    logic uses_rd_b;    // STR/SWP read rd on port B

    assign is_mem_op = (opcode == OP_LOD) || (opcode == OP_STR);
    assign uses_rd_b = (opcode == OP_STR) || (opcode == OP_SWP);

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state_q <= S_START0;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_START0:  state_d = S_START1;
            S_START1:  state_d = S_FETCH;
            S_FETCH:   state_d = S_DECODE;
            S_DECODE:  state_d = (opcode == OP_HLT) ? S_HALT : S_EXECUTE;
            S_EXECUTE: state_d = S_MEM;
            S_MEM:     state_d = S_WB;
            S_WB:      state_d = (opcode == OP_SWP) ? S_SWAP2 : S_FETCH;
            S_SWAP2:   state_d = S_FETCH;
            S_HALT:    state_d = S_HALT;
            default:   state_d = S_START0;
        endcase
    end

    // Outputs are Moore-style on state, qualified by the current opcode.
    // Asynchronous reset forces state_q to START0, so only pc_rst is high
    // while rst_f is low and every write enable drops at once.
    always_comb begin
        rf_we     = 1'b0;
        alu_op    = ALU_REG;
        wb_sel    = WB_ALU;
        rb_sel    = 1'b0;
        pc_sel    = 1'b0;
        pc_write  = 1'b0;
        pc_rst    = 1'b0;
        ir_load   = 1'b0;
        br_sel    = 1'b0;
        mm_sel    = 1'b0;
        dm_we     = 1'b0;
        swap_sel  = 1'b0;
        swap_ctrl = 1'b0;

        case (state_q)
            S_START0: begin
                pc_rst = 1'b1;
            end
            S_FETCH: begin
                ir_load  = 1'b1;
                pc_write = 1'b1;
                pc_sel   = 1'b0;
            end
            S_DECODE: begin
                rb_sel = uses_rd_b;
                br_sel = (opcode == OP_BRA) || (opcode == OP_BNE);
                if (branch_taken(opcode, mm, stat)) begin
                    pc_sel   = 1'b1;
                    pc_write = 1'b1;
                end
            end
            S_EXECUTE: begin
                rb_sel = uses_rd_b;
                mm_sel = is_mem_op & ~mm[3];
                case (opcode)
                    OP_ALUI:        alu_op = ALU_IMM;
                    OP_LOD, OP_STR: alu_op = ALU_ADR;
                    default:        alu_op = ALU_REG;
                endcase
            end
            S_MEM: begin
                rb_sel    = uses_rd_b;
                mm_sel    = is_mem_op & ~mm[3];
                dm_we     = (opcode == OP_STR);
                swap_ctrl = (opcode == OP_SWP);
            end
            S_WB: begin
                rb_sel = uses_rd_b;
                mm_sel = is_mem_op & ~mm[3];
                case (opcode)
                    OP_ALUR, OP_ALUI: begin
                        rf_we  = 1'b1;
                        wb_sel = WB_ALU;
                    end
                    OP_LOD: begin
                        rf_we  = 1'b1;
                        wb_sel = WB_DM;
                    end
                    OP_SWP: begin
                        // first half of the swap: rd <- old rs
                        rf_we  = 1'b1;
                        wb_sel = WB_RSA;
                    end
                    default: rf_we = 1'b0;
                endcase
            end
            S_SWAP2: begin
                // second half of the swap: rs <- old rd
                rb_sel   = 1'b1;
                rf_we    = 1'b1;
                wb_sel   = WB_RSB;
                swap_sel = 1'b1;
            end
            default: begin
                // START1 and HALT drive nothing
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_sisc_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_sisc_ctrl_fsm
// Description : Scoreboard bench for sisc_ctrl_fsm. Stimulus pushes the
//               expected output vector for each cycle; a monitor pops and
//               compares on the falling clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sisc_ctrl_fsm;

    logic       clk;
    logic       rst_f;
    logic [3:0] opcode;
    logic [3:0] mm;
    logic [3:0] stat;
    logic       rf_we;
    logic [1:0] alu_op;
    logic [1:0] wb_sel;
    logic       rb_sel;
    logic       pc_sel;
    logic       pc_write;
    logic       pc_rst;
    logic       ir_load;
    logic       br_sel;
    logic       mm_sel;
    logic       dm_we;
    logic       swap_sel;
    logic       swap_ctrl;

    sisc_ctrl_fsm dut (
        .clk       (clk),
        .rst_f     (rst_f),
        .opcode    (opcode),
        .mm        (mm),
        .stat      (stat),
        .rf_we     (rf_we),
        .alu_op    (alu_op),
        .wb_sel    (wb_sel),
        .rb_sel    (rb_sel),
        .pc_sel    (pc_sel),
        .pc_write  (pc_write),
        .pc_rst    (pc_rst),
        .ir_load   (ir_load),
        .br_sel    (br_sel),
        .mm_sel    (mm_sel),
        .dm_we     (dm_we),
        .swap_sel  (swap_sel),
        .swap_ctrl (swap_ctrl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output vector layout:
    // {rf_we, alu_op[1:0], wb_sel[1:0], rb_sel, pc_sel, pc_write, pc_rst,
    //  ir_load, br_sel, mm_sel, dm_we, swap_sel, swap_ctrl}
    localparam logic [14:0] Z0   = 15'h0000;
    localparam logic [14:0] RFWE = 15'h4000;
    localparam logic [14:0] AIMM = 15'h1000;
    localparam logic [14:0] AADR = 15'h2000;
    localparam logic [14:0] WDM  = 15'h0400;
    localparam logic [14:0] WRSA = 15'h0800;
    localparam logic [14:0] WRSB = 15'h0C00;
    localparam logic [14:0] RB   = 15'h0200;
    localparam logic [14:0] PCS  = 15'h0100;
    localparam logic [14:0] PCW  = 15'h0080;
    localparam logic [14:0] PCR  = 15'h0040;
    localparam logic [14:0] IRL  = 15'h0020;
    localparam logic [14:0] BRS  = 15'h0010;
    localparam logic [14:0] MMS  = 15'h0008;
    localparam logic [14:0] DMW  = 15'h0004;
    localparam logic [14:0] SWS  = 15'h0002;
    localparam logic [14:0] SWC  = 15'h0001;
    localparam logic [14:0] FET  = IRL | PCW;

    typedef struct {
        logic [14:0] v;
        string       name;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    logic [14:0] act;
    assign act = {rf_we, alu_op, wb_sel, rb_sel, pc_sel, pc_write, pc_rst,
                  ir_load, br_sel, mm_sel, dm_we, swap_sel, swap_ctrl};

    // Monitor: one expected vector per checked cycle
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            tests++;
            if (act !== e.v) begin
                fails++;
                $display("FAIL %s: got %h expected %h", e.name, act, e.v);
            end
        end
    end

    task automatic push(input logic [14:0] v, input string nm);
        exp_t e;
        e.v    = v;
        e.name = nm;
        q.push_back(e);
    endtask

    task automatic step(input logic [14:0] v, input string nm);
        @(posedge clk);
        #1;
        push(v, nm);
    endtask

    // Called at posedge+1 of a FETCH cycle; returns at posedge+1 of the
    // next FETCH cycle.
    task automatic instr(input logic [3:0] op, input logic [3:0] m,
                         input logic [3:0] st,
                         input logic [14:0] e_dec, input logic [14:0] e_ex,
                         input logic [14:0] e_mem, input logic [14:0] e_wb,
                         input bit swp, input string nm);
        opcode = op;
        mm     = m;
        stat   = st;
        push(FET, {nm, "_fetch"});
        step(e_dec, {nm, "_decode"});
        step(e_ex,  {nm, "_execute"});
        step(e_mem, {nm, "_mem"});
        step(e_wb,  {nm, "_wb"});
        if (swp) step(RB | RFWE | WRSB | SWS, {nm, "_swap2"});
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_f  = 1'b0;
        opcode = 4'b0000;
        mm     = 4'b0000;
        stat   = 4'b0000;

        // reset and start-up
        @(posedge clk); #1;
        push(PCR, "in_reset");
        @(posedge clk); #1;
        rst_f = 1'b1;
        push(PCR, "start0");
        step(Z0, "start1");
        @(posedge clk); #1;

        instr(4'b0001, 4'b0000, 4'b0000, Z0, Z0, Z0, RFWE, 1'b0, "alu_reg");
        instr(4'b0110, 4'b0000, 4'b0000, Z0, AIMM, Z0, RFWE, 1'b0, "alu_imm");
        instr(4'b0010, 4'b0001, 4'b0001, BRS | PCS | PCW, Z0, Z0, Z0, 1'b0, "bra_taken");
        instr(4'b0010, 4'b0001, 4'b0000, BRS, Z0, Z0, Z0, 1'b0, "bra_not");
        instr(4'b0101, 4'b0100, 4'b0000, PCS | PCW, Z0, Z0, Z0, 1'b0, "bnr_taken");
        instr(4'b0101, 4'b0100, 4'b0100, Z0, Z0, Z0, Z0, 1'b0, "bnr_not");
        instr(4'b0011, 4'b0000, 4'b1010, PCS | PCW, Z0, Z0, Z0, 1'b0, "brr_uncond");
        instr(4'b1001, 4'b1000, 4'b0000, RB, RB | AADR, RB | DMW, RB, 1'b0, "str");
        instr(4'b1000, 4'b0000, 4'b0000, Z0, AADR | MMS, MMS, RFWE | WDM | MMS, 1'b0, "lod");
        instr(4'b1010, 4'b0000, 4'b0000, RB, RB, RB | SWC, RB | RFWE | WRSA, 1'b1, "swp");
        instr(4'b0111, 4'b1111, 4'b1111, Z0, Z0, Z0, Z0, 1'b0, "undef_nop");

        // reset asserted during WB of an ALU instruction
        opcode = 4'b0001;
        mm     = 4'b0000;
        stat   = 4'b0000;
        push(FET, "rstwb_fetch");
        step(Z0, "rstwb_decode");
        step(Z0, "rstwb_execute");
        step(Z0, "rstwb_mem");
        @(posedge clk); #1;
        rst_f = 1'b0;
        push(PCR, "rstwb_wb_reset");
        step(PCR, "rstwb_hold");
        @(posedge clk); #1;
        rst_f = 1'b1;
        push(PCR, "restart0");
        step(Z0, "restart1");
        @(posedge clk); #1;

        // halt: all outputs quiet until reset
        opcode = 4'b1111;
        push(FET, "hlt_fetch");
        step(Z0, "hlt_decode");
        for (int i = 0; i < 10; i++) step(Z0, "halt");

        // drain scoreboard, bounded
        for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
